// File: rtl/ram_port_adapter_if.sv
// Bus bundle between an upstream requester, the ram_port_adapter and one synchronous RAM port.
// Both req and rsp channels use valid/ready: a beat transfers on a cycle where valid & ready are both 1.
interface ram_port_adapter_if #(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 12
);
   logic               req_valid;
   logic               req_ready;
   logic               req_wr;
   logic [A_WIDTH-1:0] req_addr;
   logic [D_WIDTH-1:0] req_wdata;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [D_WIDTH-1:0] rsp_rdata;
   logic [A_WIDTH-1:0] ram_addr;
   logic [D_WIDTH-1:0] ram_wdata;
   logic               ram_wr;
   logic [D_WIDTH-1:0] ram_rdata;

   // Adapter side.
   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, ram_rdata,
      output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_wr
   );

   // Requester / RAM side.
   modport master (
      output req_valid, req_wr, req_addr, req_wdata, rsp_ready, ram_rdata,
      input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_wr
   );
endinterface

// File: rtl/ram_port_adapter.sv
// Adapts a valid/ready request stream onto one synchronous RAM port and buffers
// read results in a 2-entry response FIFO so a stalled consumer never loses data.
module ram_port_adapter #(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ram_port_adapter_if.slave    bus,
   output logic [1:0]           o_dbg_count,
   output logic                 o_dbg_inflight
);

   logic [1:0]         r_count;
   logic               r_inflight;
   logic               r_wptr;
   logic               r_rptr;
   logic [D_WIDTH-1:0] r_fifo [2];

   logic               w_pop;
   logic               w_push;
   logic               w_accept;
   logic               w_space;
   logic [2:0]         w_level;

   // Slots already claimed (stored + in flight) minus the one leaving this
   // cycle; a new read may only issue if a slot is guaranteed for its data.
   always_comb begin
      w_pop    = (r_count != 2'd0) & bus.rsp_ready;
      w_push   = r_inflight;
      w_level  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_space  = (w_level <= 3'd1);
      w_accept = bus.req_valid & w_space;
   end

   // rst_n gates only the outputs; internal state is already held by the async clear.
   assign bus.req_ready = w_space & rst_n;
   assign bus.ram_wr    = bus.req_valid & bus.req_ready & bus.req_wr;
   assign bus.ram_addr  = bus.req_addr;
   assign bus.ram_wdata = bus.req_wdata;

   assign bus.rsp_valid = (r_count != 2'd0);
   assign bus.rsp_rdata = r_fifo[r_rptr];

   assign o_dbg_count    = r_count;
   assign o_dbg_inflight = r_inflight;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_accept & ~bus.req_wr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= bus.ram_rdata;
            r_wptr         <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
